fc_layer_par: RTL and testbench

Parametrised fully-connected layer: y = act(W·x + b) for an M×N signed weight matrix, with P parallel MAC lanes, runtime-loadable weights and bias, optional ReLU, and optional saturation. It sits in the layer chain between valid/ready streams. It accepts an N-word input vector and emits M words in row order. Computation of row groups overlaps output draining, and the next input vector is accepted while the previous results are still draining.

---
 rtl/fc_layer_par.sv | 213 +++++++++++++++++++++
 tb/tb_fc_layer_par.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_par.sv
// Fully-connected layer y = act(W*x + b) with P parallel MAC lanes and a P-entry output bank.
// Row groups are computed while the previous group drains from the bank.
module fc_layer_par #(
    parameter int unsigned M    = 8,
    parameter int unsigned N    = 4,
    parameter int unsigned T    = 16,
    parameter int unsigned P    = 2,
    parameter int unsigned RELU = 1,
    parameter int unsigned SAT  = 1,
    localparam int unsigned WAW = (M * N > 1) ? $clog2(M * N) : 1,
    localparam int unsigned BAW = (M > 1) ? $clog2(M) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [T-1:0]   data_in,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [T-1:0]   data_out,
    input  logic           w_wr_en,
    input  logic [WAW-1:0] w_addr,
    input  logic [T-1:0]   w_data,
    input  logic           b_wr_en,
    input  logic [BAW-1:0] b_addr,
    input  logic [T-1:0]   b_data,
    output logic           busy
);
    localparam int unsigned G    = M / P;
    localparam int unsigned GW   = (G > 1) ? $clog2(G) : 1;
    localparam int unsigned KW   = $clog2(N + 1);
    localparam int unsigned NAW  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PW   = (P > 1) ? $clog2(P) : 1;
    localparam int unsigned ACCW = 2 * T + $clog2(N + 1);

    localparam logic signed [ACCW-1:0] MaxV = {{(ACCW - T + 1){1'b0}}, {(T - 1){1'b1}}};
    localparam logic signed [ACCW-1:0] MinV = {{(ACCW - T + 1){1'b1}}, {(T - 1){1'b0}}};

    if (P < 1 || P > M || (M % P) != 0) begin : g_bad_cfg
        $error("fc_layer_par: M must be a non-zero multiple of P");
    end

    typedef enum logic [1:0] {StLoad, StCompute, StFinal} state_e;

    state_e                 state_q, state_d;
    logic [KW-1:0]          cnt_q, cnt_d;
    logic [KW-1:0]          k_q, k_d;
    logic [GW-1:0]          g_q, g_d;
    logic                   run_q;
    logic signed [ACCW-1:0] acc_q [P];
    logic signed [ACCW-1:0] acc_d [P];
    logic [T-1:0]           bank_q [P];
    logic [T-1:0]           bank_d [P];
    logic                   full_q, full_d;
    logic [PW-1:0]          rd_q, rd_d;

    logic [T-1:0]           w_mem [M*N];
    logic [T-1:0]           b_mem [M];
    logic [T-1:0]           x_mem [N];
    logic signed [T-1:0]    w_rd_q [P];
    logic signed [T-1:0]    b_rd_q [P];
    logic signed [T-1:0]    x_rd_q;

    logic [WAW-1:0]         w_raddr [P];
    logic [BAW-1:0]         b_raddr [P];
    logic signed [2*T-1:0]  prod [P];
    logic signed [ACCW-1:0] act_v [P];
    logic [T-1:0]           res [P];
    logic                   issue;
    logic                   bank_free;

    // run_q keeps s_ready low until the first edge after reset release.
    assign s_ready   = run_q && (state_q == StLoad) && (cnt_q != KW'(N));
    assign m_valid   = full_q;
    assign data_out  = full_q ? bank_q[rd_q] : '0;
    assign busy      = !((state_q == StLoad) && (cnt_q == '0) && !full_q);
    assign issue     = (state_q == StCompute) && (k_q < KW'(N));
    assign bank_free = !full_q || (m_ready && (rd_q == PW'(P - 1)));

    always_comb begin
        for (int l = 0; l < int'(P); l++) begin
            w_raddr[l] = WAW'((int'(g_q) * int'(P) + l) * int'(N) + int'(k_q));
            b_raddr[l] = BAW'(int'(g_q) * int'(P) + l);
            prod[l]    = w_rd_q[l] * x_rd_q;
        end
    end

    always_comb begin
        for (int l = 0; l < int'(P); l++) begin
            act_v[l] = acc_q[l];
            if (RELU != 0 && acc_q[l][ACCW-1]) begin
                act_v[l] = '0;
            end
            res[l] = act_v[l][T-1:0];
            if (SAT != 0) begin
                if (act_v[l] > MaxV) begin
                    res[l] = MaxV[T-1:0];
                end else if (act_v[l] < MinV) begin
                    res[l] = MinV[T-1:0];
                end
            end
        end
    end

    // Memories are not reset; reads are registered one cycle behind the issue column.
    always_ff @(posedge clk) begin
        if (w_wr_en && !busy) begin
            w_mem[w_addr] <= w_data;
        end
        if (b_wr_en && !busy) begin
            b_mem[b_addr] <= b_data;
        end
        if (s_valid && s_ready) begin
            x_mem[NAW'(cnt_q)] <= data_in;
        end
        if (issue) begin
            x_rd_q <= x_mem[NAW'(k_q)];
            for (int l = 0; l < int'(P); l++) begin
                w_rd_q[l] <= w_mem[w_raddr[l]];
                b_rd_q[l] <= b_mem[b_raddr[l]];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        g_d     = g_q;
        acc_d   = acc_q;
        bank_d  = bank_q;
        full_d  = full_q;
        rd_d    = rd_q;

        if (full_q && m_ready) begin
            if (rd_q == PW'(P - 1)) begin
                full_d = 1'b0;
                rd_d   = '0;
            end else begin
                rd_d = rd_q + 1'b1;
            end
        end

        unique case (state_q)
            StLoad: begin
                if (cnt_q == KW'(N)) begin
                    state_d = StCompute;
                    k_d     = '0;
                end else if (s_valid && s_ready) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCompute: begin
                // k_q >= 1 consumes column k_q-1; the first data cycle presets with the bias.
                if (k_q != '0) begin
                    for (int l = 0; l < int'(P); l++) begin
                        acc_d[l] = ((k_q == KW'(1)) ? {{(ACCW - T){b_rd_q[l][T-1]}}, b_rd_q[l]}
                                                    : acc_q[l])
                                   + {{(ACCW - 2 * T){prod[l][2*T-1]}}, prod[l]};
                    end
                end
                if (k_q == KW'(N)) begin
                    state_d = StFinal;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StFinal: begin
                if (bank_free) begin
                    bank_d = res;
                    full_d = 1'b1;
                    rd_d   = '0;
                    if (g_q == GW'(G - 1)) begin
                        state_d = StLoad;
                        cnt_d   = '0;
                        g_d     = '0;
                    end else begin
                        state_d = StCompute;
                        g_d     = g_q + 1'b1;
                        k_d     = '0;
                    end
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StLoad;
            cnt_q   <= '0;
            k_q     <= '0;
            g_q     <= '0;
            run_q   <= 1'b0;
            full_q  <= 1'b0;
            rd_q    <= '0;
            for (int l = 0; l < int'(P); l++) begin
                acc_q[l]  <= '0;
                bank_q[l] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            g_q     <= g_d;
            run_q   <= 1'b1;
            full_q  <= full_d;
            rd_q    <= rd_d;
            acc_q   <= acc_d;
            bank_q  <= bank_d;
        end
    end
endmodule

// File: tb/tb_fc_layer_par.sv
// Bench for fc_layer_par: directed scenarios plus randomized vectors checked against a
// plain-arithmetic reference, on three activation/saturation variants sharing one stimulus.
module tb_fc_layer_par;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s_valid = 1'b0;
    logic [7:0] data_in = '0;
    logic       m_ready = 1'b0;
    logic       w_wr_en = 1'b0;
    logic [2:0] w_addr = '0;
    logic [7:0] w_data = '0;
    logic       b_wr_en = 1'b0;
    logic [1:0] b_addr = '0;
    logic [7:0] b_data = '0;

    logic       s_ready0, m_valid0, busy0;
    logic [7:0] data_out0;
    logic       s_ready1, m_valid1, busy1;
    logic [7:0] data_out1;
    logic       s_ready2, m_valid2, busy2;
    logic [7:0] data_out2;

    fc_layer_par #(.M(4), .N(2), .T(8), .P(2), .RELU(1), .SAT(1)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready0), .data_in(data_in),
        .m_valid(m_valid0), .m_ready(m_ready), .data_out(data_out0), .w_wr_en(w_wr_en),
        .w_addr(w_addr), .w_data(w_data), .b_wr_en(b_wr_en), .b_addr(b_addr), .b_data(b_data),
        .busy(busy0)
    );
    fc_layer_par #(.M(4), .N(2), .T(8), .P(2), .RELU(0), .SAT(1)) dut_nr (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready1), .data_in(data_in),
        .m_valid(m_valid1), .m_ready(m_ready), .data_out(data_out1), .w_wr_en(w_wr_en),
        .w_addr(w_addr), .w_data(w_data), .b_wr_en(b_wr_en), .b_addr(b_addr), .b_data(b_data),
        .busy(busy1)
    );
    fc_layer_par #(.M(4), .N(2), .T(8), .P(2), .RELU(1), .SAT(0)) dut_ns (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready2), .data_in(data_in),
        .m_valid(m_valid2), .m_ready(m_ready), .data_out(data_out2), .w_wr_en(w_wr_en),
        .w_addr(w_addr), .w_data(w_data), .b_wr_en(b_wr_en), .b_addr(b_addr), .b_data(b_data),
        .busy(busy2)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int out0[$], out1[$], out2[$];
    int e0[$], e1[$], e2[$];
    int wm[4][2];
    int bm[4];
    int xm[2];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Collect handshaken words and verify that stalled words are held.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", {31'b0, m_valid0}, 1);
                chk("hold_data", 32'(data_out0), 32'(prev_data));
            end
            prev_stall <= m_valid0 && !m_ready;
            prev_data  <= data_out0;
            if (m_valid0 && m_ready) out0.push_back(int'($signed(data_out0)));
            if (m_valid1 && m_ready) out1.push_back(int'($signed(data_out1)));
            if (m_valid2 && m_ready) out2.push_back(int'($signed(data_out2)));
        end
    end

    function automatic int model(input int row, input int relu, input int sat);
        int acc;
        logic [7:0] lo;
        acc = bm[row];
        for (int c = 0; c < 2; c++) acc += wm[row][c] * xm[c];
        if (relu != 0 && acc < 0) acc = 0;
        if (sat != 0) begin
            if (acc > 127) acc = 127;
            if (acc < -128) acc = -128;
        end else begin
            lo  = acc[7:0];
            acc = int'($signed(lo));
        end
        return acc;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        out0.delete(); out1.delete(); out2.delete();
        e0.delete(); e1.delete(); e2.delete();
    endtask

    task automatic w_write(input int a, input int v);
        w_addr = 3'(a); w_data = 8'(v); w_wr_en = 1'b1;
        tick();
        w_wr_en = 1'b0;
    endtask

    task automatic b_write(input int a, input int v);
        b_addr = 2'(a); b_data = 8'(v); b_wr_en = 1'b1;
        tick();
        b_wr_en = 1'b0;
    endtask

    task automatic load_all();
        for (int r = 0; r < 4; r++) for (int c = 0; c < 2; c++) w_write(r * 2 + c, wm[r][c]);
        for (int r = 0; r < 4; r++) b_write(r, bm[r]);
    endtask

    task automatic send_vec(input int x0, input int x1, input bit rnd);
        int xs[2];
        int guard;
        xs[0] = x0; xs[1] = x1;
        xm[0] = x0; xm[1] = x1;
        for (int r = 0; r < 4; r++) begin
            e0.push_back(model(r, 1, 1));
            e1.push_back(model(r, 0, 1));
            e2.push_back(model(r, 1, 0));
        end
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1;
            data_in = 8'(xs[i]);
            guard = 0;
            while (!s_ready0 && guard < 300) begin
                if (rnd) m_ready = 1'($urandom_range(0, 1));
                tick();
                guard++;
            end
            chk("s_ready_wait", {31'b0, s_ready0}, 1);
            if (rnd) m_ready = 1'($urandom_range(0, 1));
            tick();
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_out(input int n, input bit rnd);
        int guard;
        guard = 0;
        while (out0.size() < n && guard < 2000) begin
            if (rnd) m_ready = 1'($urandom_range(0, 1));
            tick();
            guard++;
        end
        m_ready = 1'b1;
        repeat (12) tick();
        chk("out_count", out0.size(), n);
    endtask

    task automatic chk_seq(input string tag, input int a0, input int a1, input int a2,
                           input int a3, input int base);
        int ex[4];
        ex[0] = a0; ex[1] = a1; ex[2] = a2; ex[3] = a3;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s[%0d]", tag, base + i),
                (base + i < out0.size()) ? out0[base + i] : -999, ex[i]);
        end
    endtask

    task automatic compare_model(input string tag);
        chk({tag, "_cnt_nr"}, out1.size(), e1.size());
        chk({tag, "_cnt_ns"}, out2.size(), e2.size());
        for (int i = 0; i < e0.size(); i++) begin
            chk($sformatf("%s_rs[%0d]", tag, i), (i < out0.size()) ? out0[i] : -999, e0[i]);
            chk($sformatf("%s_nr[%0d]", tag, i), (i < out1.size()) ? out1[i] : -999, e1[i]);
            chk($sformatf("%s_ns[%0d]", tag, i), (i < out2.size()) ? out2[i] : -999, e2[i]);
        end
    endtask

    initial begin
        int lat;
        int guard;

        // Reset values
        #12;
        chk("rst_s_ready", {31'b0, s_ready0}, 0);
        chk("rst_m_valid", {31'b0, m_valid0}, 0);
        chk("rst_data_out", 32'(data_out0), 0);
        chk("rst_busy", {31'b0, busy0}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("s_ready_at_release", {31'b0, s_ready0}, 0);
        tick();
        chk("s_ready_after_edge", {31'b0, s_ready0}, 1);

        wm = '{'{1, 2}, '{3, 4}, '{-1, -2}, '{0, 5}};
        bm = '{1, 0, 0, -3};
        load_all();

        // Basic vector and first-output latency
        clear_q();
        m_ready = 1'b1;
        send_vec(2, 3, 0);
        lat = 0;
        while (!m_valid0 && lat < 50) begin
            tick();
            lat++;
        end
        chk("latency", lat, 5);
        wait_out(4, 0);
        chk_seq("basic", 9, 18, 0, 12, 0);

        // Backpressure: each word held for 3 cycles
        clear_q();
        m_ready = 1'b0;
        send_vec(2, 3, 0);
        for (int w = 0; w < 4; w++) begin
            guard = 0;
            while (!m_valid0 && guard < 100) begin
                tick();
                guard++;
            end
            repeat (3) tick();
            m_ready = 1'b1;
            tick();
            m_ready = 1'b0;
        end
        wait_out(4, 0);
        chk_seq("bp", 9, 18, 0, 12, 0);

        // Back-to-back vectors
        clear_q();
        m_ready = 1'b1;
        send_vec(2, 3, 0);
        guard = 0;
        while (!s_ready0 && guard < 100) begin
            tick();
            guard++;
        end
        chk("overlap_draining", {31'b0, m_valid0}, 1);
        send_vec(1, 1, 0);
        wait_out(8, 0);
        chk_seq("b2b", 9, 18, 0, 12, 0);
        chk_seq("b2b", 4, 7, 0, 2, 4);

        // Reset while a vector is partly loaded and the bank still holds results
        clear_q();
        m_ready = 1'b1;
        send_vec(2, 3, 0);
        guard = 0;
        while (out0.size() < 2 && guard < 100) begin
            tick();
            guard++;
        end
        m_ready = 1'b0;
        guard = 0;
        while (!s_ready0 && guard < 100) begin
            tick();
            guard++;
        end
        chk("pre_rst_m_valid", {31'b0, m_valid0}, 1);
        s_valid = 1'b1;
        data_in = 8'd2;
        tick();
        s_valid = 1'b0;
        chk("pre_rst_busy", {31'b0, busy0}, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_s_ready", {31'b0, s_ready0}, 0);
        chk("mid_rst_m_valid", {31'b0, m_valid0}, 0);
        chk("mid_rst_data_out", 32'(data_out0), 0);
        tick();
        tick();
        reset = 1'b0;
        clear_q();
        m_ready = 1'b1;
        send_vec(2, 3, 0);
        wait_out(4, 0);
        chk_seq("after_rst", 9, 18, 0, 12, 0);

        // Config writes while busy are ignored
        clear_q();
        send_vec(2, 3, 0);
        chk("busy_compute", {31'b0, busy0}, 1);
        w_addr = 3'd0; w_data = 8'd50; w_wr_en = 1'b1;
        b_addr = 2'd0; b_data = 8'd100; b_wr_en = 1'b1;
        tick();
        tick();
        w_wr_en = 1'b0;
        b_wr_en = 1'b0;
        wait_out(4, 0);
        chk_seq("cfg_busy_a", 9, 18, 0, 12, 0);
        clear_q();
        send_vec(2, 3, 0);
        wait_out(4, 0);
        chk_seq("cfg_busy_b", 9, 18, 0, 12, 0);

        // Saturation and truncation
        wm[0] = '{127, 127};
        bm[0] = 0;
        w_write(0, 127); w_write(1, 127); b_write(0, 0);
        clear_q();
        send_vec(127, 127, 0);
        wait_out(4, 0);
        chk("sat_pos", (out0.size() > 0) ? out0[0] : -999, 127);
        chk("trunc", (out2.size() > 0) ? out2[0] : -999, 2);
        wm[0] = '{-128, -128};
        w_write(0, -128); w_write(1, -128);
        clear_q();
        send_vec(127, 127, 0);
        wait_out(4, 0);
        chk("sat_neg", (out1.size() > 0) ? out1[0] : -999, -128);
        chk("relu_neg", (out0.size() > 0) ? out0[0] : -999, 0);

        // Randomized weights, inputs and backpressure
        for (int it = 0; it < 4; it++) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 2; c++) wm[r][c] = int'($urandom_range(0, 255)) - 128;
                bm[r] = int'($urandom_range(0, 255)) - 128;
            end
            load_all();
            clear_q();
            send_vec(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, 1);
            send_vec(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, 1);
            wait_out(8, 1);
            compare_model($sformatf("rnd%0d", it));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
